// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (CPU) has default priority, port 1 (debug/DMA)
// gets anti-starvation promotion and an optional lock to hold ownership across accesses.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic [31:0]   p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic          p1_lock,
  output logic          p1_gnt,
  output logic [31:0]   p1_rdata,
  output logic          p1_rvalid,
  output logic          m_we,
  output logic [AW-1:0] m_a,
  output logic [31:0]   m_wd,
  input  logic [31:0]   m_rd
);

  typedef enum logic [1:0] {StOwn0, StStarve, StLock1} state_e;

  localparam logic [3:0] WaitLim = 4'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        p0_win, p1_win;
  logic [31:0] p0_rdata_q, p1_rdata_q;
  logic        p0_rvalid_q, p1_rvalid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StOwn0;
      wait_cnt_q  <= 4'd0;
      p0_rdata_q  <= 32'd0;
      p1_rdata_q  <= 32'd0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      p0_rvalid_q <= p0_win & ~p0_we;
      p1_rvalid_q <= p1_win & ~p1_we;
      if (p0_win && !p0_we) p0_rdata_q <= m_rd;
      if (p1_win && !p1_we) p1_rdata_q <= m_rd;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StOwn0: begin
        if (p1_win && p1_lock)                          state_d = StLock1;
        else if (p1_req && !p1_win && wait_cnt_q >= WaitLim) state_d = StStarve;
      end
      StStarve: begin
        if (p1_win && p1_lock)     state_d = StLock1;
        else if (p1_win || !p1_req) state_d = StOwn0;
      end
      StLock1: begin
        if (!p1_lock || !p1_req) state_d = StOwn0;
      end
      default: state_d = StOwn0;
    endcase
  end

  always_comb begin
    p0_win = 1'b0;
    p1_win = 1'b0;
    case (state_q)
      StOwn0: begin
        p0_win = p0_req;
        p1_win = p1_req & ~p0_req;
      end
      StStarve: begin
        p1_win = p1_req;
        p0_win = p0_req & ~p1_req;
      end
      StLock1: p1_win = p1_req;
      default: ;
    endcase
  end

  // Saturating count of consecutive cycles port 1 has been kept waiting.
  always_comb begin
    wait_cnt_d = 4'd0;
    if (p1_req && !p1_win) begin
      wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
    end
  end

  // Grants are masked combinationally so nothing reaches memory while reset is low.
  assign p0_gnt = p0_win & reset;
  assign p1_gnt = p1_win & reset;

  always_comb begin
    m_we = 1'b0;
    m_a  = '0;
    m_wd = 32'd0;
    if (p0_gnt) begin
      m_we = p0_we;
      m_a  = p0_addr;
      m_wd = p0_wdata;
    end else if (p1_gnt) begin
      m_we = p1_we;
      m_a  = p1_addr;
      m_wd = p1_wdata;
    end
  end

  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, memory address width in bits.
REQ-002 Parameter MAX_WAIT, default 4, number of consecutive cycles port 1 may be denied before it is forced a grant; legal range 1..15.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 p0_req / p0_we  input  1 / 1  port 0 (CPU data port) access request / write enable.
REQ-006 p0_addr / p0_wdata  input  AW / 32  port 0 byte address / write data.
REQ-007 p0_gnt  output  1  port 0 access is performed this cycle.
REQ-008 p0_rdata / p0_rvalid  output  32 / 1  registered port 0 read data / valid strobe.
REQ-009 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rdata, p1_rvalid: same as port 0, for port 1 (debug/DMA).
REQ-010 p1_lock  input  1  port 1 requests that ownership be held across consecutive accesses.
REQ-011 m_we  output  1  memory write enable.
REQ-012 m_a / m_wd  output  AW / 32  memory address / write data.
REQ-013 m_rd  input  32  memory read data, combinational from m_a.

Function
REQ-014 The arbiter SHALL grant at most one port per cycle; p0_gnt and p1_gnt are never both 1.
REQ-015 Grant SHALL be combinational in the request cycle; the granted port's addr, wdata and we drive m_a, m_wd and m_we in that cycle.
REQ-016 When no port is granted: m_we = 0, m_a = 0, m_wd = 0.
REQ-017 The FSM SHALL have exactly three states: OWN0 (default priority to port 0), STARVE (port 1 forced priority) and LOCK1 (port 1 owns).
REQ-018 OWN0: p0_req wins; otherwise p1_req wins.
REQ-019 wait_cnt (4 bits) SHALL increment each cycle in which p1_req = 1 and p1_gnt = 0, and SHALL clear when p1_gnt = 1 or p1_req = 0.
REQ-020 OWN0 -> STARVE when wait_cnt reaches MAX_WAIT-1 and port 1 is again denied; in STARVE, port 1 wins over port 0.
REQ-021 STARVE -> OWN0 after one port 1 grant, or immediately if p1_req drops.
REQ-022 Any state -> LOCK1 on a p1 grant with p1_lock = 1.
REQ-023 In LOCK1, only port 1 can be granted; p0_gnt = 0 even if p0_req = 1.
REQ-024 LOCK1 -> OWN0 on the first cycle ending with p1_lock = 0 or p1_req = 0; the release cycle itself still excludes port 0.
REQ-025 On a granted read (we = 0), m_rd SHALL be captured into that port's rdata register at the next rising edge; rvalid SHALL be 1 for exactly the following cycle.
REQ-026 rdata SHALL hold its last captured value when rvalid = 0; a granted write produces no rvalid.
REQ-027 Back-to-back reads from one port SHALL give rvalid on consecutive cycles with no bubble.
REQ-028 Requests are not queued; a denied requester must hold req, we, addr and wdata stable until granted.
REQ-029 wait_cnt SHALL saturate at 15 and never wrap.

Reset
REQ-030 While reset = 0: state = OWN0, wait_cnt = 0, p0_rdata = p1_rdata = 0, p0_rvalid = p1_rvalid = 0, regardless of clk.
REQ-031 While reset = 0: p0_gnt = p1_gnt = 0 and m_we = 0, so no memory write occurs.
REQ-032 Reset asserted mid-access or in LOCK1 SHALL abort the access and discard any pending rvalid; the first cycle after release is arbitrated from OWN0.

Verification
REQ-033 Reset release, p0 read addr 0x64 with memory holding 7 -> p0_gnt = 1 in the same cycle; next cycle p0_rvalid = 1 and p0_rdata = 7.
REQ-034 p0_req and p1_req held high continuously, MAX_WAIT = 4 -> p0 granted 4 cycles, p1 granted on the 5th, then p0 resumes.
REQ-035 p1 write 0xDEADBEEF to 0x10 with p1_lock = 1 for 3 cycles while p0_req = 1 -> p0_gnt = 0 for all 3 cycles; p0 granted on the cycle after p1_lock falls; memory[0x10] = 0xDEADBEEF.
REQ-036 Simultaneous p0 write and p1 read in OWN0 -> only p0_gnt; m_we = 1; p1_rvalid stays 0 until p1 is granted.
REQ-037 reset pulsed low during LOCK1 with a read in flight -> all gnt and rvalid are 0, state is OWN0, and the next p0 request is granted immediately.
REQ-038 Idle cycle with no requests -> m_we = 0, m_a = 0, both gnt = 0, wait_cnt = 0.
